// File: rtl/regalu_sequencer.sv
// regalu_sequencer: issues one instruction at a time to regalu as a READ/WRITE select
// sequence, then holds the captured result until it is consumed. Optional counter: REGALU_SEQ_PERF_EN.
module regalu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic        instr_cin,
    input  logic [4:0]  instr_rs,
    input  logic [4:0]  instr_rt,
    input  logic [4:0]  instr_rd,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic [2:0]  S,
    output logic        Cin,
    input  logic [31:0] dbus,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
`ifdef REGALU_SEQ_PERF_EN
    ,
    output logic [15:0] retired_cnt
`endif
);

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  rd_reg;
    logic        illegal_reg;
    logic        instr_ready_reg;
    logic [31:0] aselect_reg;
    logic [31:0] bselect_reg;
    logic [31:0] dselect_reg;
    logic [2:0]  s_reg;
    logic        cin_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_data_reg;
    logic        resp_err_reg;

    logic [31:0] rs_onehot;
    logic [31:0] rt_onehot;
    logic [31:0] rd_onehot;
    logic [31:0] dest_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_decode
            assign rs_onehot[gi] = (instr_rs == 5'(gi));
            assign rt_onehot[gi] = (instr_rt == 5'(gi));
            assign rd_onehot[gi] = (rd_reg == 5'(gi));
        end
    endgenerate

    // R0 is hard-wired and an illegal op must not commit, so neither gets a write strobe.
    assign dest_onehot = (illegal_reg || rd_reg == 5'd0) ? 32'h0 : rd_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rd_reg          <= 5'd0;
            illegal_reg     <= 1'b0;
            instr_ready_reg <= 1'b1;
            aselect_reg     <= 32'h0;
            bselect_reg     <= 32'h0;
            dselect_reg     <= 32'h0;
            s_reg           <= 3'd0;
            cin_reg         <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= 32'h0;
            resp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (instr_valid) begin
                        state_reg       <= READ;
                        instr_ready_reg <= 1'b0;
                        rd_reg          <= instr_rd;
                        illegal_reg     <= (instr_op == OP_ILLEGAL);
                        aselect_reg     <= rs_onehot;
                        bselect_reg     <= rt_onehot;
                        dselect_reg     <= 32'h0;
                        s_reg           <= instr_op;
                        cin_reg         <= instr_cin;
                    end
                end
                READ: begin
                    state_reg   <= WRITE;
                    dselect_reg <= dest_onehot;
                end
                WRITE: begin
                    // regalu commits dbus on this same edge; we keep a copy for the response.
                    state_reg      <= RESP;
                    resp_data_reg  <= dbus;
                    resp_err_reg   <= illegal_reg;
                    resp_valid_reg <= 1'b1;
                    aselect_reg    <= 32'h0;
                    bselect_reg    <= 32'h0;
                    dselect_reg    <= 32'h0;
                    s_reg          <= 3'd0;
                    cin_reg        <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg       <= IDLE;
                        resp_valid_reg  <= 1'b0;
                        instr_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_reg;
    assign Aselect     = aselect_reg;
    assign Bselect     = bselect_reg;
    assign Dselect     = dselect_reg;
    assign S           = s_reg;
    assign Cin         = cin_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_data   = resp_data_reg;
    assign resp_err    = resp_err_reg;

`ifdef REGALU_SEQ_PERF_EN
    logic [15:0] retired_cnt_reg;

    // Counts completed response handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_reg <= 16'h0;
        end else if (state_reg == RESP && resp_ready) begin
            retired_cnt_reg <= retired_cnt_reg + 16'h1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_regalu_sequencer.sv
// Bench for regalu_sequencer: a small regalu stand-in drives dbus, and a register-file
// model predicts results, selects, latency and error flags for directed and random instructions.
module tb_regalu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = 3'd0;
    logic        instr_cin = 1'b0;
    logic [4:0]  instr_rs = 5'd0;
    logic [4:0]  instr_rt = 5'd0;
    logic [4:0]  instr_rd = 5'd0;
    logic [31:0] Aselect, Bselect, Dselect;
    logic [2:0]  S;
    logic        Cin;
    logic [31:0] dbus;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
`ifdef REGALU_SEQ_PERF_EN
    logic [15:0] retired_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    regalu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_cin(instr_cin),
        .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
        .Aselect(Aselect), .Bselect(Bselect), .Dselect(Dselect),
        .S(S), .Cin(Cin), .dbus(dbus),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
`ifdef REGALU_SEQ_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, want bench completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- regalu stand-in and reference model ----------------
    logic [31:0] env_regs [32];
    logic [31:0] model_regs [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [31:0] pre_val = 32'h0;
    int          a_idx, b_idx;
    logic [31:0] a_val, b_val;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic cin);
        case (op)
            3'd0: return a ^ b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a - b;
            3'd4: return a + b + {31'h0, cin};
            3'd5: return a + ~b + {31'h0, cin};
            3'd6: return a;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int sel_index(input logic [31:0] sel);
        int r;
        r = -1;
        for (int i = 31; i >= 0; i--) if (sel[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] mread(input int i);
        return (i == 0) ? 32'h0 : model_regs[i];
    endfunction

    always_comb begin
        a_idx = sel_index(Aselect);
        b_idx = sel_index(Bselect);
        a_val = 32'h0;
        b_val = 32'h0;
        if (a_idx > 0) a_val = env_regs[a_idx];
        if (b_idx > 0) b_val = env_regs[b_idx];
        dbus = alu(a_val, b_val, S, Cin);
    end

    always @(posedge clk) begin
        if (pre_we) env_regs[pre_idx] <= pre_val;
        else if (sel_index(Dselect) > 0) env_regs[sel_index(Dselect)] <= dbus;
    end

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
        model_regs[idx] = val;
    endtask

    // ---------------- transaction driver (records observations) ----------------
    logic [31:0] obs_ra, obs_rb, obs_rdsel, obs_wdsel, obs_dsel_or, obs_data;
    logic [2:0]  obs_s;
    logic        obs_cin, obs_err, obs_busy, obs_whold, obs_clear, obs_stable, obs_released;
    int          obs_lat;

    task automatic run_instr(input logic [2:0] op, input logic cin, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input int stall);
        @(negedge clk);
        instr_op = op; instr_cin = cin; instr_rs = rs; instr_rt = rt; instr_rd = rd;
        instr_valid = 1'b1;
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        obs_lat = 1;
        obs_ra = Aselect; obs_rb = Bselect; obs_s = S; obs_cin = Cin;
        obs_rdsel = Dselect; obs_dsel_or = Dselect; obs_busy = instr_ready;
        @(posedge clk); #1;
        obs_lat = 2;
        obs_wdsel = Dselect; obs_dsel_or |= Dselect;
        obs_whold = (Aselect === obs_ra) && (Bselect === obs_rb) && (S === obs_s) && (Cin === obs_cin);
        while (!resp_valid && obs_lat < 10) begin
            @(posedge clk); #1;
            obs_lat++;
            obs_dsel_or |= Dselect;
        end
        obs_data = resp_data; obs_err = resp_err;
        obs_clear = (Aselect === 32'h0) && (Bselect === 32'h0) && (Dselect === 32'h0) &&
                    (S === 3'd0) && (Cin === 1'b0);
        obs_stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== obs_data || resp_err !== obs_err ||
                instr_ready !== 1'b0) obs_stable = 1'b0;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        obs_released = (resp_valid === 1'b0) && (instr_ready === 1'b1);
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL reset_resp_data: got %h want 00000000", resp_data); end
        vectors++; if ({Aselect, Bselect, Dselect} !== 96'h0) begin miscompares++; $display("FAIL reset_selects: got %h %h %h want all zero", Aselect, Bselect, Dselect); end
        vectors++; if ({S, Cin} !== 4'h0) begin miscompares++; $display("FAIL reset_s_cin: got %b %b want 000 0", S, Cin); end
    endtask

`ifdef REGALU_SEQ_PERF_EN
    task automatic test_perf;
        for (int n = 0; n < 3; n++) run_instr(3'd2, 1'b0, 5'(n + 1), 5'(n + 2), 5'd0, 0);
        vectors++; if (retired_cnt !== 16'd3) begin miscompares++; $display("FAIL perf_three: got %0d want 3", retired_cnt); end
        @(negedge clk);
        force dut.retired_cnt_reg = 16'hFFFF;
        #1;
        release dut.retired_cnt_reg;
        run_instr(3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 0);
        vectors++; if (retired_cnt !== 16'h0) begin miscompares++; $display("FAIL perf_wrap: got %h want 0000", retired_cnt); end
    endtask
`endif

    task automatic test_directed_xor;
        run_instr(3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 0);
        model_regs[1] = 32'h0;
        vectors++; if (obs_ra !== 32'h1 || obs_rb !== 32'h1) begin miscompares++; $display("FAIL xor_read_sel: got %h %h want 00000001 00000001", obs_ra, obs_rb); end
        vectors++; if (obs_rdsel !== 32'h0) begin miscompares++; $display("FAIL xor_read_dsel: got %h want 00000000", obs_rdsel); end
        vectors++; if (obs_wdsel !== 32'h2) begin miscompares++; $display("FAIL xor_write_dsel: got %h want 00000002", obs_wdsel); end
        vectors++; if (obs_data !== 32'h0) begin miscompares++; $display("FAIL xor_data: got %h want 00000000", obs_data); end
        vectors++; if (obs_lat !== 3) begin miscompares++; $display("FAIL xor_latency: got %0d want 3", obs_lat); end
        vectors++; if (obs_busy !== 1'b0) begin miscompares++; $display("FAIL xor_busy_ready: got %b want 0", obs_busy); end
    endtask

    task automatic test_sub_chain;
        preload(5'd8, 32'hFFFFFFFF);
        preload(5'd9, 32'hFFFFFFFE);
        run_instr(3'd3, 1'b0, 5'd8, 5'd9, 5'd11, 0);
        model_regs[11] = 32'h1;
        vectors++; if (obs_ra !== 32'h100 || obs_rb !== 32'h200) begin miscompares++; $display("FAIL sub_read_sel: got %h %h want 00000100 00000200", obs_ra, obs_rb); end
        vectors++; if (obs_wdsel !== 32'h800) begin miscompares++; $display("FAIL sub_write_dsel: got %h want 00000800", obs_wdsel); end
        vectors++; if (obs_data !== 32'h1) begin miscompares++; $display("FAIL sub_data: got %h want 00000001", obs_data); end
        vectors++; if (obs_s !== 3'd3) begin miscompares++; $display("FAIL sub_s: got %0d want 3", obs_s); end
    endtask

    task automatic test_r0_and_illegal;
        logic [31:0] exp;
        preload(5'd5, 32'hA5A5_1234);
        exp = alu(mread(3), mread(4), 3'd2, 1'b1);
        run_instr(3'd2, 1'b1, 5'd3, 5'd4, 5'd0, 1);
        vectors++; if (obs_dsel_or !== 32'h0) begin miscompares++; $display("FAIL r0_dsel: got %h want 00000000", obs_dsel_or); end
        vectors++; if (obs_err !== 1'b0 || obs_data !== exp) begin miscompares++; $display("FAIL r0_resp: got err=%b data=%h want err=0 data=%h", obs_err, obs_data, exp); end
        exp = alu(mread(5), mread(6), 3'd7, 1'b0);
        run_instr(3'd7, 1'b0, 5'd5, 5'd6, 5'd5, 0);
        vectors++; if (obs_s !== 3'd7) begin miscompares++; $display("FAIL illegal_s: got %0d want 7", obs_s); end
        vectors++; if (obs_dsel_or !== 32'h0) begin miscompares++; $display("FAIL illegal_dsel: got %h want 00000000", obs_dsel_or); end
        vectors++; if (obs_err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", obs_err); end
        vectors++; if (obs_data !== exp) begin miscompares++; $display("FAIL illegal_data: got %h want %h", obs_data, exp); end
        run_instr(3'd6, 1'b0, 5'd5, 5'd0, 5'd0, 0);
        vectors++; if (obs_data !== 32'hA5A5_1234) begin miscompares++; $display("FAIL illegal_r5_kept: got %h want a5a51234", obs_data); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp1, exp2;
        logic [4:0]  rs2;
        int          k;
        exp1 = alu(mread(12), mread(13), 3'd4, 1'b1);
        @(negedge clk);
        instr_op = 3'd4; instr_cin = 1'b1; instr_rs = 5'd12; instr_rt = 5'd13; instr_rd = 5'd20;
        instr_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 8) begin @(posedge clk); #1; k++; end
        model_regs[20] = exp1;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resp_valid: got %b want 1", resp_valid); end
        rs2 = 5'($urandom_range(1, 31));
        exp2 = alu(mread(int'(rs2)), mread(20), 3'd0, 1'b0);
        @(negedge clk);
        instr_op = 3'd0; instr_cin = 1'b0; instr_rs = rs2; instr_rt = 5'd20; instr_rd = 5'd21;
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== exp1 || instr_ready !== 1'b0 || Aselect !== 32'h0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b asel=%h want 1 %h 0 00000000", c, resp_valid, resp_data, instr_ready, Aselect, exp1);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        vectors++; if (resp_valid !== 1'b0 || instr_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", resp_valid, instr_ready); end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        vectors++; if (instr_ready !== 1'b0 || Aselect !== (32'h1 << rs2)) begin miscompares++; $display("FAIL bp_next_accept: got ready=%b asel=%h want 0 %h", instr_ready, Aselect, 32'h1 << rs2); end
        k = 0;
        while (!resp_valid && k < 8) begin @(posedge clk); #1; k++; end
        model_regs[21] = exp2;
        vectors++; if (resp_valid !== 1'b1 || resp_data !== exp2) begin miscompares++; $display("FAIL bp_second_data: got valid=%b data=%h want 1 %h", resp_valid, resp_data, exp2); end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic        cin;
        logic [4:0]  rs, rt, rd;
        int          stall;
        logic [31:0] exp, exp_d;
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(0, 7));
            cin = 1'($urandom_range(0, 1));
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            stall = int'($urandom_range(0, 3));
            exp = alu(mread(int'(rs)), mread(int'(rt)), op, cin);
            exp_d = (op != 3'd7 && rd != 5'd0) ? (32'h1 << rd) : 32'h0;
            run_instr(op, cin, rs, rt, rd, stall);
            if (exp_d != 32'h0) model_regs[rd] = exp;
            vectors++; if (obs_data !== exp || obs_err !== (op == 3'd7)) begin miscompares++; $display("FAIL rand%0d_resp: got data=%h err=%b want %h %b", n, obs_data, obs_err, exp, op == 3'd7); end
            vectors++; if (obs_ra !== (32'h1 << rs) || obs_rb !== (32'h1 << rt) || obs_s !== op || obs_cin !== cin) begin miscompares++; $display("FAIL rand%0d_read: got %h %h %0d %b want %h %h %0d %b", n, obs_ra, obs_rb, obs_s, obs_cin, 32'h1 << rs, 32'h1 << rt, op, cin); end
            vectors++; if (obs_wdsel !== exp_d || obs_rdsel !== 32'h0) begin miscompares++; $display("FAIL rand%0d_dsel: got read=%h write=%h want 00000000 %h", n, obs_rdsel, obs_wdsel, exp_d); end
            vectors++; if (obs_lat !== 3 || obs_whold !== 1'b1) begin miscompares++; $display("FAIL rand%0d_timing: got lat=%0d hold=%b want 3 1", n, obs_lat, obs_whold); end
            vectors++; if (obs_clear !== 1'b1 || obs_stable !== 1'b1 || obs_released !== 1'b1) begin miscompares++; $display("FAIL rand%0d_resp_phase: got clear=%b stable=%b released=%b want 1 1 1", n, obs_clear, obs_stable, obs_released); end
        end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] old;
        preload(5'd12, 32'h0BAD_F00D);
        old = 32'h0BAD_F00D;
        @(negedge clk);
        instr_op = 3'd2; instr_cin = 1'b0; instr_rs = 5'd3; instr_rt = 5'd4; instr_rd = 5'd12;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (Dselect !== (32'h1 << 12)) begin miscompares++; $display("FAIL rmw_write_dsel: got %h want 00001000", Dselect); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if ({Aselect, Bselect, Dselect} !== 96'h0) begin miscompares++; $display("FAIL rmw_async_clear: got %h %h %h want all zero", Aselect, Bselect, Dselect); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (instr_ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_after_release: got ready=%b valid=%b want 1 0", instr_ready, resp_valid); end
        run_instr(3'd6, 1'b0, 5'd12, 5'd0, 5'd0, 0);
        vectors++; if (obs_data !== old) begin miscompares++; $display("FAIL rmw_target_kept: got %h want %h", obs_data, old); end
    endtask

    initial begin
        test_reset();
        for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
        model_regs[0] = 32'h0;
`ifdef REGALU_SEQ_PERF_EN
        test_perf();
`endif
        test_directed_xor();
        test_sub_chain();
        test_r0_and_illegal();
        test_backpressure();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regalu_sequencer.md
REGALU_SEQUENCER -- requirements
Module: regalu_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock shared with regalu.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  an encoded instruction is offered.
REQ-005 instr_ready  output  1  the sequencer can accept an instruction.
REQ-006 instr_op  input  3  ALU select code, forwarded to S; 3'b111 is illegal.
REQ-007 instr_cin  input  1  carry-in for the ALU.
REQ-008 instr_rs, instr_rt, instr_rd  input  5 each  source-A, source-B and destination register indices.
REQ-009 Aselect, Bselect, Dselect  output  32 each  one-hot register selects driven to regalu.
REQ-010 S  output  3  ALU operation.
REQ-011 Cin  output  1  ALU carry-in.
REQ-012 dbus  input  32  result bus returned from regalu.
REQ-013 resp_valid  output  1  a retired-instruction response is available.
REQ-014 resp_ready  input  1  the consumer accepts the response.
REQ-015 resp_data  output  32  dbus value captured at writeback.
REQ-016 resp_err  output  1  the retired instruction was illegal.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, WRITE and RESP.
REQ-018 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on a rising edge where instr_valid=1 and instr_ready=1.
REQ-019 On accept, the sequencer SHALL latch op, cin, rs, rt and rd, then go IDLE->READ.
REQ-020 In READ:
- Aselect=1<<rs, Bselect=1<<rt, S=op, Cin=cin, Dselect=0.
- The next state SHALL be WRITE unconditionally.
REQ-021 In WRITE:
- Aselect, Bselect, S and Cin SHALL hold their READ values.
- Dselect=1<<rd.
- dbus SHALL be captured into resp_data on the WRITE->RESP edge.
REQ-022 In RESP, resp_valid=1 and resp_data/resp_err SHALL be stable; RESP->IDLE occurs on the edge where resp_ready=1.
REQ-023 Latency: resp_valid SHALL rise exactly 3 rising edges after the accept edge (accept, READ->WRITE, WRITE->RESP).
REQ-024 Writes to R0 (rd=0): Dselect SHALL be 32'h0 in WRITE, the sequence SHALL otherwise complete normally, and resp_err=0.
REQ-025 Illegal op (3'b111):
- S SHALL be driven to 3'b111 as given.
- Dselect SHALL be 32'h0 in WRITE.
- resp_err SHALL be 1.
- resp_data SHALL still capture dbus.
REQ-026 Outside READ and WRITE, Aselect, Bselect and Dselect SHALL be 32'h0, and S and Cin SHALL be 0.
REQ-027 A new instruction SHALL NOT be accepted before the previous response handshake completes, so no read-after-write hazard exists.
REQ-028 resp_ready held high in IDLE, READ or WRITE SHALL have no effect.
REQ-029 All outputs SHALL be registered; none SHALL depend combinationally on instr_* or resp_ready.

Reset
REQ-030 Asserting rst_n=0 in any state SHALL force IDLE immediately.
REQ-031 Reset values SHALL be:
- Aselect, Bselect, Dselect: 32'h0.
- S, Cin: 0.
- resp_valid, resp_err: 0.
- resp_data: 32'h0.
- instr_ready: 1 after release.
REQ-032 Reset asserted mid-WRITE SHALL deassert Dselect asynchronously, so no register write is issued on the next edge.

Configuration
REQ-033 The macro REGALU_SEQ_PERF_EN SHALL control an optional retired-instruction counter.
REQ-034 With REGALU_SEQ_PERF_EN defined:
- The block SHALL add output retired_cnt (16 bits).
- retired_cnt SHALL increment by 1 on each RESP->IDLE edge, illegal ops included.
- retired_cnt SHALL wrap from 16'hFFFF to 16'h0000.
- retired_cnt SHALL reset to 0.
REQ-035 Without REGALU_SEQ_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Directed XOR: accept op=000, rs=0, rt=0, rd=1 with resp_ready=1 -> in READ, Aselect=Bselect=32'h1; in WRITE, Dselect=32'h2; resp_data=32'h00000000; resp_valid rises 3 edges after accept.
REQ-037 Directed SUB chain: preload R8=32'hFFFFFFFF and R9=32'hFFFFFFFE, then op=011, rs=8, rt=9, rd=11 -> Aselect=32'h100, Bselect=32'h200, Dselect=32'h800, resp_data=32'h00000001.
REQ-038 R0 write and illegal op:
- rd=0 -> Dselect stays 32'h0 throughout.
- op=111, rd=5 -> Dselect stays 32'h0, resp_err=1, R5 is unchanged when read back.
REQ-039 Back-pressure: hold resp_ready=0 for 10 cycles in RESP -> resp_valid=1 with resp_data stable, instr_ready=0, a pending instr_valid is not accepted; it is accepted on the first edge after the RESP->IDLE handshake.
REQ-040 Reset mid-WRITE: pull rst_n low during WRITE -> all selects are 0 immediately; after release, state is IDLE, instr_ready=1, and the target register holds its old value.
REQ-041 With REGALU_SEQ_PERF_EN: retire 3 instructions -> retired_cnt=3; force the counter to 16'hFFFF and retire 1 -> retired_cnt=0.
